// File: rtl/fios_job_arbiter_pkg.sv
// fios_job_arbiter_pkg: shared FSM states and sizing helpers for the job arbiter.
// ABORT exists only when FIOS_ARB_TIMEOUT_EN is defined.
package fios_job_arbiter_pkg;
`ifdef FIOS_ARB_TIMEOUT_EN
  typedef enum logic [2:0] {IDLE, ARB, START, RUN, DONE, ABORT} state_e;
`else
  typedef enum logic [2:0] {IDLE, ARB, START, RUN, DONE} state_e;
`endif
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic logic [31:0] win_words(input int sec);
    return 32'(4 * sec);
  endfunction
endpackage

// File: rtl/fios_job_arbiter_if.sv
// fios_job_arbiter_if: requester handshake plus core control/address signals.
interface fios_job_arbiter_if #(
  parameter int N_REQ = 2
) ();
  logic [N_REQ-1:0] req_i;
  logic [N_REQ-1:0] grant_o;
  logic [N_REQ-1:0] done_o;
  logic [N_REQ-1:0] err_o;
  logic             busy_o;
  logic             core_start_o;
  logic             core_done_i;
  logic             core_reset_o;
  logic [31:0]      core_addr_i;
  logic [31:0]      bram_addr_o;
  modport slave (
    input  req_i, core_done_i, core_addr_i,
    output grant_o, done_o, err_o, busy_o, core_start_o, core_reset_o, bram_addr_o
  );
  modport master (
    output req_i, core_done_i, core_addr_i,
    input  grant_o, done_o, err_o, busy_o, core_start_o, core_reset_o, bram_addr_o
  );
endinterface

// File: rtl/fios_job_arbiter_rr_picker.sv
// fios_rr_picker: combinational round-robin pick starting after last owner.
module fios_rr_picker
  import fios_job_arbiter_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int IW = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last,
  output logic [N_REQ-1:0] gnt,
  output logic [IW-1:0]    idx
);
  logic [IW-1:0] k;
  // scan farthest-first so the nearest requester after last overwrites
  always_comb begin
    gnt = '0;
    idx = '0;
    k = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      k = IW'((int'(last) + i) % N_REQ);
      if (req[k]) begin
        gnt = '0;
        gnt[k] = 1'b1;
        idx = k;
      end
    end
  end
endmodule

// File: rtl/fios_job_arbiter.sv
// fios_job_arbiter: round-robin owner of one shared multiplier core.
// FIOS_ARB_TIMEOUT_EN adds a RUN watchdog that aborts a stalled job.
module fios_job_arbiter
  import fios_job_arbiter_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int s = 8,
  parameter int TIMEOUT = 4096
) (
  input logic clock_i,
  input logic reset_i,
  fios_job_arbiter_if.slave bus
);
  localparam int IW = idx_w(N_REQ);
  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 2) begin : g_bad_cfg
    $error("fios_job_arbiter: illegal parameters");
  end
  state_e state_q, state_d;
  logic [N_REQ-1:0] req_q, req_d, grant_q, grant_d, pick_gnt;
  logic [IW-1:0] owner_q, owner_d, last_q, last_d, pick_idx;
`ifdef FIOS_ARB_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  logic [WW-1:0] wd_q, wd_d;
`endif
  fios_rr_picker #(.N_REQ(N_REQ)) u_pick (
    .req (req_q),
    .last(last_q),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );
  // requests are frozen on leaving IDLE so later req_i edges cannot move the pick
  always_comb begin
    state_d = state_q;
    req_d = req_q;
    grant_d = grant_q;
    owner_d = owner_q;
    last_d = last_q;
`ifdef FIOS_ARB_TIMEOUT_EN
    wd_d = '0;
`endif
    case (state_q)
      IDLE: if (|bus.req_i) begin
        state_d = ARB;
        req_d = bus.req_i;
      end
      ARB: begin
        state_d = START;
        grant_d = pick_gnt;
        owner_d = pick_idx;
        last_d = pick_idx;
      end
      START: state_d = RUN;
      RUN: if (bus.core_done_i) state_d = DONE;
`ifdef FIOS_ARB_TIMEOUT_EN
      else if (wd_q == WW'(TIMEOUT - 1)) state_d = ABORT;
      else wd_d = wd_q + 1'b1;
      ABORT: if (wd_q == '0) wd_d = 1'b1;
      else begin
        state_d = IDLE;
        grant_d = '0;
      end
`endif
      DONE: begin
        state_d = IDLE;
        grant_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      req_q <= '0;
      grant_q <= '0;
      owner_q <= '0;
      last_q <= IW'(N_REQ - 1);
`ifdef FIOS_ARB_TIMEOUT_EN
      wd_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      req_q <= req_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      last_q <= last_d;
`ifdef FIOS_ARB_TIMEOUT_EN
      wd_q <= wd_d;
`endif
    end
  end
  assign bus.grant_o = grant_q;
  assign bus.done_o = state_q == DONE ? grant_q : '0;
  assign bus.busy_o = state_q != IDLE;
  assign bus.core_start_o = state_q == START;
  assign bus.bram_addr_o = bus.core_addr_i + (|grant_q ? 32'(owner_q) * win_words(s) : 32'd0);
`ifdef FIOS_ARB_TIMEOUT_EN
  assign bus.err_o = (state_q == ABORT && wd_q == '0) ? grant_q : '0;
  assign bus.core_reset_o = reset_i | (state_q == ABORT);
`else
  assign bus.err_o = '0;
  assign bus.core_reset_o = reset_i;
`endif
endmodule

// File: doc/fios_job_arbiter.md
FIOS_JOB_ARBITER -- requirements
Module: fios_job_arbiter

Interface
REQ-001 Parameter N_REQ, default 2: number of requesters sharing one multiplier core; legal range 2..8.
REQ-002 Parameter s, default 8: operand section count; each requester owns a BRAM window of 4*s words.
REQ-003 Parameter TIMEOUT, default 4096: watchdog limit in cycles, used only when the timeout feature is compiled in.
REQ-004 clock_i  in  1  single clock; all logic on its rising edge.
REQ-005 reset_i  in  1  synchronous, active-high reset.
REQ-006 req_i  in  N_REQ  level request per requester; held until done_o or err_o for that requester.
REQ-007 grant_o  out  N_REQ  one-hot owner of the core; all zero when no requester owns it.
REQ-008 done_o  out  N_REQ  one-cycle pulse to the owner on job completion.
REQ-009 err_o  out  N_REQ  one-cycle pulse to the owner on watchdog abort.
REQ-010 busy_o  out  1  high whenever state is not IDLE.
REQ-011 core_start_o  out  1  one-cycle start pulse to the core.
REQ-012 core_done_i  in  1  core completion pulse.
REQ-013 core_reset_o  out  1  synchronous reset to the core.
REQ-014 core_addr_i  in  32  BRAM word address issued by the core.
REQ-015 bram_addr_o  out  32  core_addr_i + owner_index*4*s, combinational; equals core_addr_i when no owner.

Function
REQ-016 FSM states SHALL be IDLE, ARB, START, RUN, DONE and ABORT.
- IDLE->ARB when any req_i bit is high.
- ARB->START unconditionally; grant_o registered in ARB.
- START->RUN with core_start_o high for exactly the START cycle.
- RUN->DONE on core_done_i.
- DONE->IDLE with done_o[owner] high for exactly the DONE cycle; grant_o cleared on entry to IDLE.
REQ-017 Arbitration SHALL be round-robin: search starts at (last_owner+1) mod N_REQ; last_owner resets to N_REQ-1, so requester 0 wins first.
REQ-018 Latency: req_i rising in IDLE at cycle t SHALL give grant_o at t+2 and core_start_o at t+2, when no job is in progress.
REQ-019 done_o SHALL pulse the cycle after core_done_i is sampled in RUN.
REQ-020 core_done_i outside RUN SHALL be ignored.
REQ-021 req_i changes while a job is in progress SHALL be ignored; a withdrawn owner request still runs to completion and receives done_o.
REQ-022 A req_i bit still high in IDLE after its done_o SHALL count as a new request, subject to round-robin order.
REQ-023 Simultaneous requests SHALL be served one job each, in round-robin order, with no requester skipped.
REQ-024 The owner index SHALL stay stable from ARB through DONE; bram_addr_o SHALL use that index.

Reset
REQ-025 On reset_i: state IDLE, grant_o=0, done_o=0, err_o=0, busy_o=0, core_start_o=0, last_owner=N_REQ-1, watchdog=0.
REQ-026 core_reset_o SHALL equal reset_i OR the abort pulse; reset mid-job SHALL abandon the job with no done_o.

Configuration
REQ-027 Macro FIOS_ARB_TIMEOUT_EN.
- Defined: a watchdog counts cycles in RUN. Reaching TIMEOUT-1 without core_done_i enters ABORT. ABORT lasts 2 cycles, drives core_reset_o high, pulses err_o[owner] in its first cycle, then returns to IDLE. last_owner is updated as for a normal job.
- Undefined: no counter, no ABORT state, err_o tied to 0, core_reset_o = reset_i.

Structure
REQ-028 A shared package SHALL hold the state enum typedef, the BRAM window-size function (4*s) and the owner-index width ($clog2(N_REQ)).
REQ-029 One sub-module, fios_rr_picker, SHALL be combinational: inputs request vector and last_owner; outputs one-hot grant and index.

Verification
REQ-030 Single job: req_i=01, core_done_i pulsed 40 cycles after core_start_o -> grant_o=01, one core_start_o pulse, done_o=01 one cycle after core_done_i.
REQ-031 Contention: req_i=11 held from reset -> requester 0 served first, then requester 1; two start pulses, done_o 01 then 10.
REQ-032 Address offset: s=8, owner 1, core_addr_i=5 -> bram_addr_o=37.
REQ-033 Withdrawal: req_i[0] dropped during RUN -> job completes, done_o[0] still pulses, then IDLE.
REQ-034 Timeout (macro defined, TIMEOUT=16): no core_done_i -> err_o[owner] and a 2-cycle core_reset_o 16 cycles after entering RUN, then IDLE; with macro undefined, FSM stays in RUN.
REQ-035 Reset mid-RUN: reset_i high 1 cycle -> all outputs 0 next cycle, no done_o, requester 0 has priority again.
